// File: rtl/verificador_senha_pkg.sv
// Shared door-lock definitions: packed keypad entry buffer, special nibble codes
// and the entry-classification helpers used by both the keypad decoder and the verifier.
package verificador_senha_pkg;

    localparam int NUM_DIG = 20;

    typedef struct packed {
        logic [NUM_DIG-1:0][3:0] digits;
    } senhaPac_t;

    localparam logic [3:0] DIG_VAZIO   = 4'hF;
    localparam logic [3:0] DIG_TIMEOUT = 4'hE;
    localparam logic [3:0] DIG_CONFIG  = 4'hB;
    localparam logic [3:0] DIG_ESTRELA = 4'hA;

    // Shortest entry that may ever unlock the door.
    localparam logic [4:0] MIN_DIGITOS = 5'd4;

    function automatic logic todos_iguais(input senhaPac_t s, input logic [3:0] nib);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            r = r & (s.digits[i] == nib);
        end
        return r;
    endfunction

    function automatic logic [4:0] num_digitos(input senhaPac_t s);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < NUM_DIG; i++) begin
            n = n + {4'd0, (s.digits[i] != DIG_VAZIO)};
        end
        return n;
    endfunction

endpackage

// File: rtl/verificador_senha_if.sv
// Verifier bus: keypad entry strobe and stored-password table in, verdict,
// configuration request and lockout status out.
interface verificador_senha_if #(
    parameter int NUM_SENHAS = 4
) ();
    import verificador_senha_pkg::*;

    localparam int IDXW = (NUM_SENHAS > 1) ? $clog2(NUM_SENHAS) : 1;

    logic            enable;
    senhaPac_t       digitos_value;
    logic            digitos_valid;
    senhaPac_t       senhas_cfg [NUM_SENHAS];
    logic            senha_ok;
    logic            senha_erro;
    logic [IDXW-1:0] slot_idx;
    logic            cfg_req;
    logic            bloqueado;
    logic            ocupado;

    modport master (
        output enable, digitos_value, digitos_valid, senhas_cfg,
        input  senha_ok, senha_erro, slot_idx, cfg_req, bloqueado, ocupado
    );

    modport slave (
        input  enable, digitos_value, digitos_valid, senhas_cfg,
        output senha_ok, senha_erro, slot_idx, cfg_req, bloqueado, ocupado
    );

endinterface

// File: rtl/verificador_senha.sv
// Door-lock password verifier: scans the stored slots one per clock, reports the
// verdict and holds a timed lockout after MAX_TENTATIVAS consecutive failures.
module verificador_senha
    import verificador_senha_pkg::*;
#(
    parameter int NUM_SENHAS     = 4,
    parameter int MAX_TENTATIVAS = 3,
    parameter int BLOQ_CICLOS    = 30000
) (
    input  logic               clk,
    input  logic               rst,
    verificador_senha_if.slave bus
);

    localparam int IDXW = (NUM_SENHAS > 1) ? $clog2(NUM_SENHAS) : 1;
    localparam int FALW = $clog2(MAX_TENTATIVAS + 1);
    localparam int BLQW = $clog2(BLOQ_CICLOS + 1);
    localparam logic [IDXW-1:0] ULTIMO  = IDXW'(NUM_SENHAS - 1);
    localparam logic [FALW-1:0] FAL_MAX = FALW'(MAX_TENTATIVAS);
    localparam logic [BLQW-1:0] BLQ_MAX = BLQW'(BLOQ_CICLOS);

    typedef enum logic [1:0] {IDLE, COMPARE, RESULT, BLOQUEADO} estado_t;

    estado_t         estado_q;
    senhaPac_t       entrada_q;
    logic            curta_q;
    logic [IDXW-1:0] idx_q;
    logic            achou_q;
    logic [IDXW-1:0] achado_q;
    logic [FALW-1:0] falhas_q;
    logic [BLQW-1:0] bloq_cnt_q;
    logic            senha_ok_q;
    logic            senha_erro_q;
    logic [IDXW-1:0] slot_idx_q;
    logic            cfg_req_q;
    logic            bloqueado_q;
    logic            ocupado_q;

    logic            slot_hit_s;
    logic            acerto_s;
    logic [IDXW-1:0] idx_final_s;
    logic [FALW-1:0] falhas_inc_s;

    // Match of the slot under the index counter, plus the verdict as seen on the last slot.
    always_comb begin
        slot_hit_s   = !curta_q
                     && !todos_iguais(bus.senhas_cfg[idx_q], DIG_VAZIO)
                     && (bus.senhas_cfg[idx_q] == entrada_q);
        acerto_s     = achou_q | slot_hit_s;
        idx_final_s  = achou_q ? achado_q : idx_q;
        falhas_inc_s = (falhas_q >= FAL_MAX) ? FAL_MAX : (falhas_q + FALW'(1));
    end

    // Verifier FSM; every output is a register so pulses land exactly in the RESULT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= IDLE;
            entrada_q    <= '0;
            curta_q      <= 1'b0;
            idx_q        <= '0;
            achou_q      <= 1'b0;
            achado_q     <= '0;
            falhas_q     <= '0;
            bloq_cnt_q   <= '0;
            senha_ok_q   <= 1'b0;
            senha_erro_q <= 1'b0;
            slot_idx_q   <= '0;
            cfg_req_q    <= 1'b0;
            bloqueado_q  <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            senha_ok_q   <= 1'b0;
            senha_erro_q <= 1'b0;
            slot_idx_q   <= '0;
            cfg_req_q    <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (bus.enable && bus.digitos_valid) begin
                        if (todos_iguais(bus.digitos_value, DIG_CONFIG)) begin
                            cfg_req_q <= 1'b1;
                        end else if (!todos_iguais(bus.digitos_value, DIG_TIMEOUT)
                                  && !todos_iguais(bus.digitos_value, DIG_VAZIO)) begin
                            entrada_q <= bus.digitos_value;
                            curta_q   <= (num_digitos(bus.digitos_value) < MIN_DIGITOS);
                            idx_q     <= '0;
                            achou_q   <= 1'b0;
                            achado_q  <= '0;
                            ocupado_q <= 1'b1;
                            estado_q  <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    if (!bus.enable) begin
                        ocupado_q <= 1'b0;
                        estado_q  <= IDLE;
                    end else if (idx_q == ULTIMO) begin
                        estado_q <= RESULT;
                        if (acerto_s) begin
                            senha_ok_q <= 1'b1;
                            slot_idx_q <= idx_final_s;
                            falhas_q   <= '0;
                        end else begin
                            senha_erro_q <= 1'b1;
                            falhas_q     <= falhas_inc_s;
                            if (falhas_inc_s == FAL_MAX) begin
                                bloqueado_q <= 1'b1;
                                bloq_cnt_q  <= BLQW'(1);
                            end
                        end
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                        if (slot_hit_s && !achou_q) begin
                            achou_q  <= 1'b1;
                            achado_q <= idx_q;
                        end
                    end
                end
                // bloq_cnt_q counts the cycles bloqueado has been high, RESULT included.
                RESULT, BLOQUEADO: begin
                    if (bloqueado_q) begin
                        if (bloq_cnt_q >= BLQ_MAX) begin
                            bloqueado_q <= 1'b0;
                            ocupado_q   <= 1'b0;
                            bloq_cnt_q  <= '0;
                            falhas_q    <= '0;
                            estado_q    <= IDLE;
                        end else begin
                            bloq_cnt_q <= bloq_cnt_q + BLQW'(1);
                            estado_q   <= BLOQUEADO;
                        end
                    end else begin
                        ocupado_q <= 1'b0;
                        estado_q  <= IDLE;
                    end
                end
                default: begin
                    bloqueado_q <= 1'b0;
                    ocupado_q   <= 1'b0;
                    estado_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.senha_ok   = senha_ok_q;
    assign bus.senha_erro = senha_erro_q;
    assign bus.slot_idx   = slot_idx_q;
    assign bus.cfg_req    = cfg_req_q;
    assign bus.bloqueado  = bloqueado_q;
    assign bus.ocupado    = ocupado_q;

endmodule

// File: doc/verificador_senha.md
# verificador_senha

Password verifier for the door lock. Consumes the packed digit buffer and the one-cycle `digitos_valid` strobe produced by the keypad decoder. Compares each submitted entry against a table of stored passwords, one slot per clock. Reports success or failure, forwards configuration requests, and enforces a timed lockout after repeated failures.

## Interface
- `NUM_SENHAS`, 4: number of stored password slots (≥1).
- `MAX_TENTATIVAS`, 3: consecutive failures that trigger lockout (≥1).
- `BLOQ_CICLOS`, 30000: lockout duration in clk cycles.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  block enable, sampled synchronously.
- `digitos_value`  in  senhaPac_t  20-nibble entry buffer; `digits[0]` is the most recent key; 4'hF marks an empty nibble.
- `digitos_valid`  in  1  one-cycle strobe; `digitos_value` is meaningful only while it is high.
- `senhas_cfg`  in  senhaPac_t [NUM_SENHAS]  stored passwords, F-padded in the upper nibbles; an all-F slot is unused.
- `senha_ok`  out  1  one-cycle pulse: the entry matched a slot.
- `senha_erro`  out  1  one-cycle pulse: the entry matched no slot.
- `slot_idx`  out  $clog2(NUM_SENHAS) (min 1)  matched slot index; meaningful only while `senha_ok` is high.
- `cfg_req`  out  1  one-cycle pulse: a configuration request (all-B entry) was received.
- `bloqueado`  out  1  level: lockout is active.
- `ocupado`  out  1  level: new strobes are being dropped (compare, result or lockout).

## Operation
- States: IDLE, COMPARE, RESULT, BLOQUEADO. On reset: IDLE, all outputs 0, failure counter 0, lockout counter 0.
- IDLE, when `digitos_valid` = 1 and `enable` = 1, classify the entry:
  - all 20 nibbles 4'hE (timeout marker): ignored; no attempt counted.
  - all 20 nibbles 4'hF (`*` pressed with no digits): ignored.
  - all 20 nibbles 4'hB: `cfg_req` pulses; state stays IDLE.
  - otherwise: capture the entry into an internal register and go to COMPARE.
- COMPARE: examines slot i on the i-th cycle, for i = 0..NUM_SENHAS-1.
  - A slot matches when it is not all-F and all 80 bits equal the captured entry.
  - When several slots match, the lowest index wins.
  - An entry with fewer than 4 non-F nibbles never matches.
  - After the last slot, go to RESULT.
- RESULT:
  - On a match: `senha_ok` = 1, `slot_idx` driven, failure counter cleared, next state IDLE.
  - Otherwise: `senha_erro` = 1 and the failure counter increments, saturating at MAX_TENTATIVAS. If the counter reaches MAX_TENTATIVAS, next state is BLOQUEADO; otherwise IDLE.
- BLOQUEADO:
  - `bloqueado` = 1 and the lockout counter counts up.
  - After BLOQ_CICLOS cycles: return to IDLE, clear both counters, `bloqueado` = 0.
  - All strobes are ignored, including all-B and all-E entries.
- `enable` = 0:
  - IDLE ignores strobes.
  - COMPARE aborts to IDLE with no result pulse and no counter change.
  - BLOQUEADO keeps counting; disabling does not shorten a lockout.
  - The failure counter is retained.
- Strobes arriving in COMPARE, RESULT or BLOQUEADO are dropped; there is no queuing.

## Timing
- Strobe accepted at cycle T:
  - COMPARE occupies T+1 .. T+NUM_SENHAS.
  - The result pulse occurs at T+NUM_SENHAS+1, independent of where the match occurs.
  - IDLE again at T+NUM_SENHAS+2.
- All-B strobe at T: `cfg_req` high at T+1 only.
- `ocupado` is high from T+1 through the RESULT cycle, and throughout BLOQUEADO.
- Lockout timing:
  - `bloqueado` rises in the RESULT cycle of the failure that reaches the limit, in the same cycle as `senha_erro`.
  - It stays high for exactly BLOQ_CICLOS cycles.
  - A strobe in the first cycle after `bloqueado` falls is accepted.
- `rst` during any state: immediate return to IDLE with all outputs 0. Any in-flight lockout is cancelled.
- All outputs are registered. Lockout counter width is $clog2(BLOQ_CICLOS+1).

## Structure
- Shared lock package holds:
  - `senhaPac_t`.
  - Nibble constants: DIG_VAZIO 4'hF, DIG_TIMEOUT 4'hE, DIG_CONFIG 4'hB, DIG_ESTRELA 4'hA.
  - Helper functions `todos_iguais(senhaPac_t, nibble)` and `num_digitos(senhaPac_t)`, so decoder and verifier share one definition.
- No sub-module. Comparison is one 80-bit equality against the slot selected by a `$clog2(NUM_SENHAS)` index counter.

## Test plan
- Slot 2 = F…F1234 (all other slots F); submit F…F1234 → `senha_ok` and `slot_idx` = 2, exactly 5 cycles after the strobe; no `senha_erro`.
- Submit F…F9999 three times with MAX_TENTATIVAS = 3 → three `senha_erro` pulses. `bloqueado` rises with the third pulse and stays high for BLOQ_CICLOS cycles. A correct entry during the lockout produces no pulse; a correct entry after the lockout produces `senha_ok`.
- Two failures, then the correct password, then one failure → no lockout; the counter restarts from 0 after the success.
- All-E strobe, then all-F strobe, then all-B strobe → only `cfg_req` pulses, one cycle after the all-B strobe; the failure counter is unchanged.
- Slots 1 and 3 both = F…F0000; submit it → `slot_idx` = 1. Submit F…F012 (3 digits) when stored as such → `senha_erro`.
- Strobe, then `enable` = 0 in the second COMPARE cycle → no result pulse. `rst` asserted in BLOQUEADO → `bloqueado` = 0 immediately and the next strobe is accepted.
